exec_stage: RTL
===============

# exec_stage

Execute stage that sits directly downstream of the instruction fetch in `core`. It consumes the 16-bit ops fetched from the code RAM, executes a small register ISA against an 8×16-bit register file, drives the core's LED nibble, and sends branch redirects back to fetch. It discards wrong-path ops by tag-matching each op's fetch address, so fetch may keep streaming after a redirect.

## Interface
Parameters:
- `op_width`, 16: op word width; the encoding below requires 16.
- `addr_width`, 9: code address width; matches the code RAM depth of 512.

Ports:
- `clock` in 1: the only clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `running` in 1: level from `core_control`; low means held in reset state.
- `op_valid` in 1: fetch presents an op this cycle.
- `op` in 16: op word.
- `op_ip` in 9: code address the op was fetched from.
- `op_ready` out 1: stage accepts the op this cycle.
- `redirect` out 1: one-cycle pulse; fetch must restart at `redirect_ip`.
- `redirect_ip` out 9: branch target, valid while `redirect`=1.
- `leds` out 4: drives `disp.led[9:6]`.
- `halted` out 1: HALT retired.
- `illegal` out 1: sticky flag; an undefined opcode retired.
- `retire_count` out 16: number of ops retired, wraps.

## Operation
- Encoding: opcode=`op[15:12]`, rd=`op[11:9]`, rs=`op[8:6]`, imm8=`op[7:0]`, imm9=`op[8:0]`.
- r0 reads as 0; writes to r0 are dropped.
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDI: rd = zext(imm8).
  - 0x2 ADD: rd = rd + rs mod 2^16.
  - 0x3 SUB: rd = rd − rs mod 2^16.
  - 0x4 ADDI: rd = rd + sext(imm8) mod 2^16.
  - 0x5 OUT: leds = rs[3:0].
  - 0x6 BNZ: if rd≠0, target = op_ip + sext(imm8) mod 512.
  - 0x7 JMP: target = imm9.
  - 0xF HALT.
  - 0x8–0xE: executes as NOP and sets `illegal`.
- States:
  - IDLE (running=0): every register and output is 0; `expected_ip`=0.
  - RUN: entered on the first edge with running=1.
  - HALT: entered when HALT retires. Left only to IDLE, when running=0.
- `op_ready` = (state==RUN) && running.
- Accept = op_valid && op_ready. An accepted op retires only if op_ip == expected_ip. A mismatched accepted op is dropped silently: no state change and no count.
- On retire:
  - Non-taken instructions set expected_ip = op_ip+1 mod 512.
  - A taken BNZ or a JMP sets expected_ip = target and registers a redirect.
  - retire_count increments by 1.
- Register file writes at the retire edge. The next op reads the new value; there are no hazards or stalls.

## Timing
- Reset (reset_n=0, asynchronous): all outputs are 0, the register file is 0, state=IDLE, expected_ip=0.
- Latency: an op accepted at edge N has its effects (register, leds, flags, count) visible after edge N.
- `redirect` is high for exactly the one cycle following the retire edge of the branch, with `redirect_ip`=target. It is 0 otherwise; `redirect_ip` holds its last value.
- Back-to-back taken branches are impossible: after a redirect, the next retiring op must carry op_ip=target.
- Branch target wraps: op_ip=5 with imm8=0xF0 gives target 0x1F5. op_ip=0x1FF as a non-branch gives expected_ip=0.
- running falling with op_valid=1 on the same edge: the op is not accepted, and the stage goes to IDLE on that edge, clearing all state. Any pending redirect pulse is suppressed.
- HALT retire edge: halted=1 and op_ready=0 from the next cycle. No redirect is issued.
- reset_n asserted mid-operation clears state immediately, independent of `clock`.
- retire_count wraps from 0xFFFF to 0x0000.

## Test plan
- Reset then running=1 with op_ip 0,1,2 carrying LDI r1,0x05; ADDI r1,0xFF; OUT r1 -> leds=4, retire_count=3, redirect never asserted.
- LDI r2,3 at 0; ADDI r2,0xFF at 1; BNZ r2,0xFF at 2, then fetch streams 3,4,1,2,… -> redirects to 1 twice, ops at 3/4 dropped, loop exits when r2=0, and retire_count counts only matching ops.
- JMP 0x1FF at ip 0, then op_ip 1 (wrong path) and 0x1FF NOP, then ip 0 -> op at 1 dropped, the 0x1FF op retires, expected_ip wraps to 0.
- Op 0x9000 at ip 0, then LDI r0,0xAA -> illegal=1 (sticky), r0 still reads 0 via OUT r0 giving leds=0.
- HALT at ip 0 with op_valid held high -> halted=1, op_ready=0, count frozen at 1. Then running=0 for one cycle and back to 1 -> all outputs 0, op at ip 0 accepted.
- reset_n pulsed low between clock edges mid-loop -> outputs clear immediately with no clock edge needed.

Source files
------------

// File: rtl/exec_stage.sv
// Execute stage: runs the small 16-bit register ISA on ops streamed from fetch,
// drops wrong-path ops by matching each op's fetch address, and issues branch redirects.
module exec_stage #(
  parameter int op_width   = 16,
  parameter int addr_width = 9
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  running,
  input  logic                  op_valid,
  input  logic [op_width-1:0]   op,
  input  logic [addr_width-1:0] op_ip,
  output logic                  op_ready,
  output logic                  redirect,
  output logic [addr_width-1:0] redirect_ip,
  output logic [3:0]            leds,
  output logic                  halted,
  output logic                  illegal,
  output logic [15:0]           retire_count
);

  typedef enum logic [1:0] {
    st_idle,
    st_run,
    st_halt
  } state_t;

  localparam logic [3:0] opc_nop  = 4'h0;
  localparam logic [3:0] opc_ldi  = 4'h1;
  localparam logic [3:0] opc_add  = 4'h2;
  localparam logic [3:0] opc_sub  = 4'h3;
  localparam logic [3:0] opc_addi = 4'h4;
  localparam logic [3:0] opc_out  = 4'h5;
  localparam logic [3:0] opc_bnz  = 4'h6;
  localparam logic [3:0] opc_jmp  = 4'h7;
  localparam logic [3:0] opc_halt = 4'hF;

  state_t                state, state_d;
  logic [op_width-1:0]   regs [8];
  logic [addr_width-1:0] expected_ip;

  logic [3:0]            opcode;
  logic [2:0]            rd, rs;
  logic [op_width-1:0]   rd_val, rs_val, imm8_sext;
  logic                  accept, retire;
  logic                  wr_en, taken, is_out, is_halt, is_illegal;
  logic [op_width-1:0]   wr_data;
  logic [addr_width-1:0] target, ip_next;

  assign opcode    = op[15:12];
  assign rd        = op[11:9];
  assign rs        = op[8:6];
  assign rd_val    = (rd == 3'd0) ? '0 : regs[rd];
  assign rs_val    = (rs == 3'd0) ? '0 : regs[rs];
  assign imm8_sext = {{(op_width-8){op[7]}}, op[7:0]};
  assign ip_next   = op_ip + addr_width'(1);

  assign op_ready = (state == st_run) && running;
  assign halted   = (state == st_halt);
  assign accept   = op_valid && op_ready;
  // Ops whose fetch address does not match are wrong-path leftovers after a redirect.
  assign retire   = accept && (op_ip == expected_ip);

  // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    wr_en      = 1'b0;
    wr_data    = rd_val;
    taken      = 1'b0;
    target     = op[addr_width-1:0];
    is_out     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      opc_nop:  ;
      opc_ldi:  begin wr_en = 1'b1; wr_data = {{(op_width-8){1'b0}}, op[7:0]}; end
      opc_add:  begin wr_en = 1'b1; wr_data = rd_val + rs_val; end
      opc_sub:  begin wr_en = 1'b1; wr_data = rd_val - rs_val; end
      opc_addi: begin wr_en = 1'b1; wr_data = rd_val + imm8_sext; end
      opc_out:  is_out = 1'b1;
      opc_bnz:  begin
        taken  = (rd_val != '0);
        target = op_ip + imm8_sext[addr_width-1:0];
      end
      opc_jmp:  taken = 1'b1;
      opc_halt: is_halt = 1'b1;
      default:  is_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state;
    if (!running) begin
      state_d = st_idle;
    end else begin
      case (state)
        st_idle: state_d = st_run;
        st_run:  if (retire && is_halt) state_d = st_halt;
        default: state_d = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= st_idle;
    else          state <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the register file is small and must read 0 after reset, so it lives in flops with reset.
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      expected_ip  <= '0;
      redirect     <= 1'b0;
      redirect_ip  <= '0;
      leds         <= '0;
      illegal      <= 1'b0;
      retire_count <= '0;
    end else if (!running) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      expected_ip  <= '0;
      redirect     <= 1'b0;
      redirect_ip  <= '0;
      leds         <= '0;
      illegal      <= 1'b0;
      retire_count <= '0;
    end else begin
      redirect <= 1'b0;
      if (retire) begin
        retire_count <= retire_count + 16'd1;
        expected_ip  <= taken ? target : ip_next;
        if (taken) begin
          redirect    <= 1'b1;
          redirect_ip <= target;
        end
        if (wr_en && rd != 3'd0) regs[rd] <= wr_data;
        if (is_out)              leds     <= rs_val[3:0];
        if (is_illegal)          illegal  <= 1'b1;
      end
    end
  end

endmodule
